// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   Multi-channel key debouncer and event generator. Each channel has a
//   2-flop synchroniser, a CE-paced stability window, and a small FSM that
//   turns a held key into press, long-press, auto-repeat and release pulses.
//   Channels share nothing except CLK, CLR_N and CE_IN.
//
// Ports
//   CLK          system clock, rising edge
//   CLR_N        asynchronous active-low reset, clears all state to 0
//   CE_IN        one-CLK sample strobe from the prescaler
//   KEY_IN       raw key inputs, active-high, asynchronous
//   KEY_LEVEL    debounced key level
//   KEY_PRESS    one-CLK pulse on debounced 0->1
//   KEY_RELEASE  one-CLK pulse on debounced 1->0
//   KEY_LONG     one-CLK pulse when the hold reaches LONG_CNT samples
//   KEY_REPEAT   one-CLK pulse every REPEAT_CNT samples after KEY_LONG
//
// Per-channel FSM
//   state | meaning
//   IDLE  | debounced level is 0
//   HELD  | level is 1, counting samples toward a long press
//   LONG  | long press reported, counting samples toward each repeat
module key_debounce_multi #(
  parameter int N_KEYS     = 4,
  parameter int STABLE_CNT = 3,
  parameter int LONG_CNT   = 100,
  parameter int REPEAT_CNT = 20,
  parameter int REPEAT_EN  = 1
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              CE_IN,
  input  logic [N_KEYS-1:0] KEY_IN,
  output logic [N_KEYS-1:0] KEY_LEVEL,
  output logic [N_KEYS-1:0] KEY_PRESS,
  output logic [N_KEYS-1:0] KEY_RELEASE,
  output logic [N_KEYS-1:0] KEY_LONG,
  output logic [N_KEYS-1:0] KEY_REPEAT
);

  if (N_KEYS < 1 || STABLE_CNT < 1 || LONG_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_param
    $error("key_debounce_multi: N_KEYS, STABLE_CNT, LONG_CNT and REPEAT_CNT must all be >= 1");
  end

  localparam int CNT_W  = $clog2(STABLE_CNT + 1);
  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  localparam int REP_W  = $clog2(REPEAT_CNT + 1);

  // Terminal values: the event fires on the sample that would make the
  // counter reach its full count, so compare against count-1.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CNT - 1);
  localparam logic              REP_ON    = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } key_state_t;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic              sync_1, sync_2;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              level_q, press_q, release_q, long_q, rep_q;
    key_state_t        state;
    logic              differ;
    logic              accept;

    assign differ = (sync_2 != level_q);
    // Level toggle decided on this edge; overrides any hold/repeat event.
    assign accept = differ && (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
        sync_1 <= 1'b0;
        sync_2 <= 1'b0;
      end else begin
        sync_1 <= KEY_IN[i];
        sync_2 <= sync_1;
      end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
        cnt       <= '0;
        hold_cnt  <= '0;
        rep_cnt   <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        rep_q     <= 1'b0;
        state     <= IDLE;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        rep_q     <= 1'b0;
        if (CE_IN) begin
          if (!differ) begin
            cnt <= '0;
          end else if (accept) begin
            cnt     <= '0;
            level_q <= ~level_q;
            if (level_q) release_q <= 1'b1;
            else         press_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end

          case (state)
            IDLE: begin
              if (accept && !level_q) begin
                state    <= HELD;
                hold_cnt <= '0;
              end
            end
            HELD: begin
              if (accept) begin
                state <= IDLE;
              end else if (hold_cnt == HOLD_LAST) begin
                state   <= LONG;
                long_q  <= 1'b1;
                rep_cnt <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            LONG: begin
              if (accept) begin
                state <= IDLE;
              end else if (rep_cnt == REP_LAST) begin
                rep_cnt <= '0;
                rep_q   <= REP_ON;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end

    assign KEY_LEVEL[i]   = level_q;
    assign KEY_PRESS[i]   = press_q;
    assign KEY_RELEASE[i] = release_q;
    assign KEY_LONG[i]    = long_q;
    assign KEY_REPEAT[i]  = rep_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Testbench for key_debounce_multi: table-driven vectors for clean press,
// bounce rejection and long/repeat with CE every cycle, plus hand-written
// sequences for CE-paced long/repeat/release, release racing long, CE gating
// and asynchronous reset in the LONG state. A second instance with
// REPEAT_EN=0 shares all inputs.
module tb_key_debounce_multi;
  logic       CLK = 1'b0;
  logic       CLR_N;
  logic       CE_IN;
  logic [3:0] KEY_IN;

  logic [3:0] d_lvl, d_prs, d_rel, d_lng, d_rpt;
  logic [3:0] n_lvl, n_prs, n_rel, n_lng, n_rpt;

  key_debounce_multi #(.N_KEYS(4), .STABLE_CNT(3), .LONG_CNT(8), .REPEAT_CNT(4), .REPEAT_EN(1)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .CE_IN(CE_IN), .KEY_IN(KEY_IN),
    .KEY_LEVEL(d_lvl), .KEY_PRESS(d_prs), .KEY_RELEASE(d_rel),
    .KEY_LONG(d_lng), .KEY_REPEAT(d_rpt)
  );

  key_debounce_multi #(.N_KEYS(4), .STABLE_CNT(3), .LONG_CNT(8), .REPEAT_CNT(4), .REPEAT_EN(0)) dut_nr (
    .CLK(CLK), .CLR_N(CLR_N), .CE_IN(CE_IN), .KEY_IN(KEY_IN),
    .KEY_LEVEL(n_lvl), .KEY_PRESS(n_prs), .KEY_RELEASE(n_rel),
    .KEY_LONG(n_lng), .KEY_REPEAT(n_rpt)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic stray;

  typedef struct {
    logic [3:0] key;
    logic [3:0] lvl, prs, rel, lng, rpt;
  } vec_t;

  vec_t tbl[18];

  // Packed output word: {level, press, release, long, repeat}
  function automatic logic [19:0] pk(input logic [3:0] l, p, r, g, t);
    return {l, p, r, g, t};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got lvl/prs/rel/lng/rpt=%h expected %h", name, act, exp);
    end
  endtask

  task automatic check_both(input string name, input logic [19:0] exp);
    check({name, " dut"}, pk(d_lvl, d_prs, d_rel, d_lng, d_rpt), exp);
    check({name, " nr"}, pk(n_lvl, n_prs, n_rel, n_lng, n_rpt), {exp[19:4], 4'h0});
  endtask

  task automatic step(input logic ce);
    CE_IN = ce;
    @(posedge CLK);
    #1;
  endtask

  // One CE sample every 4 CLK; pulses seen on the idle clocks are strays.
  task automatic ce_sample();
    repeat (3) begin
      step(1'b0);
      stray = stray | (|{d_prs, d_rel, d_lng, d_rpt, n_prs, n_rel, n_lng, n_rpt});
    end
    step(1'b1);
  endtask

  task automatic do_reset(input string name);
    CLR_N  = 1'b0;
    CE_IN  = 1'b0;
    KEY_IN = 4'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLR_N = 1'b1;
    check_both({name, " reset"}, 20'h0);
  endtask

  initial begin
    CLR_N  = 1'b0;
    CE_IN  = 1'b0;
    KEY_IN = 4'h0;
    stray  = 1'b0;

    //          key   lvl   prs   rel   lng   rpt
    tbl[0]  = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{4'h3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[6]  = '{4'h3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{4'h3, 4'h3, 4'h2, 4'h0, 4'h0, 4'h0};
    tbl[8]  = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[9]  = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[10] = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[12] = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0};
    tbl[13] = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[14] = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[15] = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h2, 4'h0};
    tbl[16] = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[17] = '{4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};

    // Clean press on key 0 and bouncy press on key 1, CE every cycle
    do_reset("tbl");
    for (int r = 0; r < 18; r++) begin
      KEY_IN = tbl[r].key;
      step(1'b1);
      check_both($sformatf("tbl[%0d]", r),
                 pk(tbl[r].lvl, tbl[r].prs, tbl[r].rel, tbl[r].lng, tbl[r].rpt));
    end

    // Long press, repeats, then release racing a repeat; CE every 4 CLK
    do_reset("seqA");
    stray = 1'b0;
    KEY_IN = 4'h4;
    for (int n = 1; n <= 32; n++) begin
      if (n == 25) KEY_IN = 4'h0;
      ce_sample();
      check_both($sformatf("seqA n=%0d", n),
                 pk((n >= 3 && n < 27) ? 4'h4 : 4'h0,
                    (n == 3) ? 4'h4 : 4'h0,
                    (n == 27) ? 4'h4 : 4'h0,
                    (n == 11) ? 4'h4 : 4'h0,
                    (n == 15 || n == 19 || n == 23) ? 4'h4 : 4'h0));
    end
    check("seqA stray pulses", {19'h0, stray}, 20'h0);

    // Release accepted on the sample that would complete LONG_CNT
    do_reset("seqB");
    stray = 1'b0;
    KEY_IN = 4'h4;
    for (int n = 1; n <= 16; n++) begin
      if (n == 9) KEY_IN = 4'h0;
      ce_sample();
      check_both($sformatf("seqB n=%0d", n),
                 pk((n >= 3 && n < 11) ? 4'h4 : 4'h0,
                    (n == 3) ? 4'h4 : 4'h0,
                    (n == 11) ? 4'h4 : 4'h0,
                    4'h0, 4'h0));
    end
    check("seqB stray pulses", {19'h0, stray}, 20'h0);

    // CE gated off while key 3 rises, then resumed
    do_reset("seqC");
    KEY_IN = 4'h8;
    for (int c = 0; c < 50; c++) begin
      step(1'b0);
      check_both($sformatf("seqC gated c=%0d", c), 20'h0);
    end
    step(1'b1);
    check_both("seqC ce1", 20'h0);
    step(1'b1);
    check_both("seqC ce2", 20'h0);
    step(1'b1);
    check_both("seqC ce3", pk(4'h8, 4'h8, 4'h0, 4'h0, 4'h0));
    step(1'b0);
    check_both("seqC after", pk(4'h8, 4'h0, 4'h0, 4'h0, 4'h0));

    // Async reset while key 0 is in LONG, key still held
    do_reset("seqD");
    KEY_IN = 4'h1;
    for (int c = 1; c <= 13; c++) step(1'b1);
    check_both("seqD long", pk(4'h1, 4'h0, 4'h0, 4'h1, 4'h0));
    step(1'b1);
    step(1'b1);
    #3;
    CLR_N = 1'b0;
    #1;
    check_both("seqD async clr", 20'h0);
    @(negedge CLK);
    @(negedge CLK);
    CLR_N = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step(1'b1);
      check_both($sformatf("seqD re-press c=%0d", c),
                 (c == 5) ? pk(4'h1, 4'h1, 4'h0, 4'h0, 4'h0) : 20'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Multi-channel debouncer and key-event generator.
- Generalises the single-key 3-sample edge detector to N keys, with a parametrised stability window, debounced level output, press/release pulses, long-press detection and optional auto-repeat.
- Sits between the raw button pins and the LED-driver control logic.
- Sampling is paced by the prescaler CE.

Parameters:
- N_KEYS, 4, number of independent key channels (>=1).
- STABLE_CNT, 3, consecutive CE samples that must differ from the debounced level before it toggles (>=1).
- LONG_CNT, 100, CE samples of held level after a press before KEY_LONG fires (>=1).
- REPEAT_CNT, 20, CE samples between KEY_REPEAT pulses after a long press (>=1).
- REPEAT_EN, 1, 1 enables auto-repeat; 0 forces KEY_REPEAT to 0.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- CLR_N  in  1  asynchronous, active-low reset.
- CE_IN  in  1  sample-enable strobe from the prescaler, one CLK wide.
- KEY_IN  in  N_KEYS  raw asynchronous key inputs, active-high.
- KEY_LEVEL  out  N_KEYS  debounced key level.
- KEY_PRESS  out  N_KEYS  one-CLK pulse on debounced 0->1.
- KEY_RELEASE  out  N_KEYS  one-CLK pulse on debounced 1->0.
- KEY_LONG  out  N_KEYS  one-CLK pulse when the hold reaches LONG_CNT.
- KEY_REPEAT  out  N_KEYS  one-CLK pulse every REPEAT_CNT samples after KEY_LONG.

Behaviour:
- Reset: CLR_N low asynchronously clears every register, including synchronisers, counters, FSMs and all outputs, to 0. All outputs are registered.
- Synchroniser: KEY_IN passes through a 2-flop synchroniser per channel, clocked every CLK regardless of CE_IN. The second stage is s[i].
- Channels are fully independent; there is no shared state except CE_IN.
- Stability counter cnt[i], width $clog2(STABLE_CNT+1), updates only on cycles with CE_IN=1:
  - s[i]==KEY_LEVEL[i]: cnt<=0.
  - s[i]!=KEY_LEVEL[i] and cnt==STABLE_CNT-1: KEY_LEVEL toggles, cnt<=0, and the matching PRESS/RELEASE pulse is asserted at the same edge.
  - Otherwise: cnt<=cnt+1.
  - Any matching sample inside the window restarts it (glitch rejection).
- Latency: KEY_LEVEL follows a clean KEY_IN edge after 2 CLK of synchronisation plus STABLE_CNT CE samples. The output updates at the edge of the STABLE_CNT-th differing sample.
- Per-channel FSM, states IDLE, HELD, LONG:
  - IDLE: on accepted press -> HELD; hold_cnt<=0.
  - HELD: each CE with level held, hold_cnt++. When hold_cnt reaches LONG_CNT -> LONG, KEY_LONG pulse, rep_cnt<=0. Accepted release -> IDLE, with a KEY_RELEASE pulse and no KEY_LONG.
  - LONG: each CE, rep_cnt++. When rep_cnt reaches REPEAT_CNT, KEY_REPEAT pulse (if REPEAT_EN) and rep_cnt<=0. Accepted release -> IDLE with KEY_RELEASE.
- Counter widths: hold_cnt is $clog2(LONG_CNT+1) and rep_cnt is $clog2(REPEAT_CNT+1). Neither counter advances outside its state, so neither can wrap.
- Pulses:
  - Every pulse output is high for exactly one CLK, the cycle after the deciding CE edge. It is cleared on the next edge even if CE_IN is high again.
  - No pulses occur without a CE_IN cycle.
- Simultaneous events:
  - Release accepted on the same CE that would complete LONG_CNT or REPEAT_CNT: only KEY_RELEASE fires.
  - At most one of PRESS/RELEASE/LONG/REPEAT is high per channel per cycle.
  - Multiple channels may pulse in the same cycle.
- CE_IN held low: all counters, levels and FSMs freeze (synchronisers keep running).
- Reset mid-operation: everything clears immediately. A key still held after reset release is re-debounced from level 0 and produces a fresh KEY_PRESS after STABLE_CNT samples.
- Elaboration fails (generate-time error) if any count parameter is below 1.

Test Plan:
- Clean press, all CE_IN=1, N_KEYS=4, STABLE_CNT=3: KEY_IN[0] 0->1 and held -> KEY_LEVEL[0]=1 and KEY_PRESS[0] one-cycle pulse exactly 5 CLK after the input edge (2 sync + 3 samples); other channels stay 0.
- Bounce rejection: KEY_IN[1] high for 2 CE samples, low 1, high 3 -> exactly one KEY_PRESS[1], at the 3rd sample of the final run; no pulse from the 2-sample burst.
- Long press and repeat, LONG_CNT=8, REPEAT_CNT=4, CE every 4 CLK: hold key 2 -> KEY_LONG[2] 8 CE samples after KEY_PRESS, KEY_REPEAT[2] every 4 samples thereafter. Release -> one KEY_RELEASE, no further repeats. Rerun with REPEAT_EN=0 -> KEY_REPEAT stays 0.
- Release racing long: release key so the 3rd stable-low sample coincides with hold_cnt reaching LONG_CNT -> KEY_RELEASE only, KEY_LONG never pulses.
- CE gating: CE_IN=0 for 50 CLK while KEY_IN[3] goes high -> no output change. Resume CE -> press accepted after 3 CE samples.
- Async reset while in LONG with KEY_IN held: CLR_N low mid-cycle -> all outputs 0 immediately, before the next CLK edge. After release of CLR_N -> KEY_PRESS re-fires after 2 CLK + 3 samples.
